// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_queue
// Description : Instruction-fetch front end with a DEPTH-entry prefetch
//               buffer. Issues in-order word fetches to instruction memory,
//               pairs returning words with their PC, and hands them to decode
//               over a valid/ready port. An EX redirect flushes the buffer,
//               retargets fetch, and arranges for in-flight responses to be
//               discarded.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               redirect_i, redirect_pc_i       - EX redirect and its target
//               imem_req_valid_o/ready_i/addr_o - fetch request channel
//               imem_rsp_valid_i/data_i         - in-order fetch responses
//               inst_valid_o/ready_i            - decode handshake
//               inst_o, pc_o, pc_plus4_o        - head instruction and its PC
//               count_o                         - allocated entries
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       imem_req_valid_o,
    input  logic                       imem_req_ready_i,
    output logic [XLEN-1:0]            imem_req_addr_o,
    input  logic                       imem_rsp_valid_i,
    input  logic [31:0]                imem_rsp_data_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [31:0]                inst_o,
    output logic [XLEN-1:0]            pc_o,
    output logic [XLEN-1:0]            pc_plus4_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam int                 c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(DEPTH);

    // Registered state
    logic [XLEN-1:0]    fetch_pc_q,   fetch_pc_d;
    logic [c_ptr_w-1:0] head_q,       head_d;
    logic [c_ptr_w-1:0] tail_q,       tail_d;
    logic [c_ptr_w-1:0] fill_ptr_q,   fill_ptr_d;   // oldest unfilled entry
    logic [c_cnt_w-1:0] count_q,      count_d;
    logic [c_cnt_w-1:0] unfilled_q,   unfilled_d;   // allocated, awaiting data
    logic [c_cnt_w-1:0] drop_cnt_q,   drop_cnt_d;   // responses still to discard
    logic [XLEN-1:0]    ent_pc_q     [DEPTH];
    logic [XLEN-1:0]    ent_pc_d     [DEPTH];
    logic [31:0]        ent_inst_q   [DEPTH];
    logic [31:0]        ent_inst_d   [DEPTH];
    logic [DEPTH-1:0]   ent_filled_q, ent_filled_d;

    // Combinational control
    logic               w_credit_ok;
    logic               w_alloc;
    logic               w_pop;
    logic               w_fill;
    logic               w_drop;
    logic [c_cnt_w:0]   w_drop_sum;

    // Every outstanding request owns either a buffer entry or a drop credit,
    // so count + drop_cnt bounds the responses that can still arrive.
    assign w_credit_ok      = ({1'b0, count_q} + {1'b0, drop_cnt_q}) < c_depth;
    assign imem_req_valid_o = !redirect_i && w_credit_ok;
    assign imem_req_addr_o  = fetch_pc_q;
    assign w_alloc          = imem_req_valid_o && imem_req_ready_i;

    assign inst_valid_o = (count_q != '0) && ent_filled_q[head_q] && !redirect_i;
    assign w_pop        = inst_valid_o && inst_ready_i;
    assign inst_o       = ent_inst_q[head_q];
    assign pc_o         = ent_pc_q[head_q];
    assign pc_plus4_o   = pc_o + XLEN'(4);
    assign count_o      = count_q;

    assign w_fill = imem_rsp_valid_i && !redirect_i && (drop_cnt_q == '0)
                    && (unfilled_q != '0);
    assign w_drop = imem_rsp_valid_i && !redirect_i && (drop_cnt_q != '0);

    // On redirect every unfilled entry becomes a response to throw away; a
    // response arriving in the redirect cycle itself is discarded at once.
    always_comb begin
        w_drop_sum = {1'b0, drop_cnt_q} + {1'b0, unfilled_q};
        if (imem_rsp_valid_i && (w_drop_sum != '0)) begin
            w_drop_sum = w_drop_sum - (c_cnt_w + 1)'(1);
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_ptr_d   = fill_ptr_q;
        count_d      = count_q;
        unfilled_d   = unfilled_q;
        drop_cnt_d   = drop_cnt_q;
        ent_pc_d     = ent_pc_q;
        ent_inst_d   = ent_inst_q;
        ent_filled_d = ent_filled_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            head_d     = tail_q;
            fill_ptr_d = tail_q;
            count_d    = '0;
            unfilled_d = '0;
            drop_cnt_d = w_drop_sum[c_cnt_w-1:0];
        end else begin
            if (w_alloc) begin
                ent_pc_d[tail_q]     = fetch_pc_q;
                ent_filled_d[tail_q] = 1'b0;
                tail_d               = tail_q + c_ptr_one;
                fetch_pc_d           = fetch_pc_q + XLEN'(4);
            end
            // fill_ptr never equals tail while an allocate is possible, so
            // the two writes above and below cannot hit the same entry.
            if (w_fill) begin
                ent_inst_d[fill_ptr_q]   = imem_rsp_data_i;
                ent_filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d               = fill_ptr_q + c_ptr_one;
            end
            if (w_drop) begin
                drop_cnt_d = drop_cnt_q - c_cnt_w'(1);
            end
            if (w_pop) begin
                head_d = head_q + c_ptr_one;
            end
            count_d    = count_q + c_cnt_w'(w_alloc) - c_cnt_w'(w_pop);
            unfilled_d = unfilled_q + c_cnt_w'(w_alloc) - c_cnt_w'(w_fill);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            fill_ptr_q   <= '0;
            count_q      <= '0;
            unfilled_q   <= '0;
            drop_cnt_q   <= '0;
            ent_filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]   <= '0;
                ent_inst_q[i] <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_ptr_q   <= fill_ptr_d;
            count_q      <= count_d;
            unfilled_q   <= unfilled_d;
            drop_cnt_q   <= drop_cnt_d;
            ent_filled_q <= ent_filled_d;
            ent_pc_q     <= ent_pc_d;
            ent_inst_q   <= ent_inst_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing waiting for it and nothing to discard means
    // the memory broke the one-response-per-request contract.
    always @(posedge clk) begin
        if (rst_n && imem_rsp_valid_i) begin
            assert ((unfilled_q != '0) || (drop_cnt_q != '0))
                else $error("if_prefetch_queue: unexpected imem response");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_queue
// Description : Directed self-checking bench for if_prefetch_queue
//               (DEPTH=4, RESET_PC=0x100) with a fixed-latency in-order
//               instruction memory that returns ~addr as the instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    if_prefetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o),
        .count_o          (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    int          mem_lat = 1;
    int          edge_no = 0;
    int          n_req   = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    initial begin
        logic        hs;
        logic [31:0] hs_addr;
        logic        used;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        forever begin
            @(negedge clk);
            #4;
            hs      = imem_req_valid_o && imem_req_ready_i && rst_n;
            hs_addr = imem_req_addr_o;
            used    = imem_rsp_valid_i;
            if (hs) n_req++;
            @(posedge clk);
            #1;
            edge_no++;
            if (!rst_n) begin
                mq_addr.delete();
                mq_due.delete();
            end else begin
                if (used && mq_due.size() > 0) begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
                if (hs) begin
                    mq_addr.push_back(hs_addr);
                    mq_due.push_back(edge_no + mem_lat);
                end
            end
            if (mq_due.size() > 0 && mq_due[0] == edge_no + 1) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = ~mq_addr[0];
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        rst_n            = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;
        mem_lat          = 1;

        // Reset values
        tick();
        tick();
        chk("rst_count",  32'(count_o), 32'd0);
        chk("rst_valid",  32'(inst_valid_o), 32'd0);
        chk("rst_inst",   inst_o, 32'h0);
        chk("rst_pc",     pc_o, 32'h0);
        chk("rst_pc4",    pc_plus4_o, 32'h4);
        rst_n = 1'b1;
        #1;
        chk("rel_reqv",   32'(imem_req_valid_o), 32'd1);
        chk("rel_addr",   imem_req_addr_o, 32'h100);

        // Streaming, single-cycle memory
        tick();
        chk("s_valid0",   32'(inst_valid_o), 32'd0);
        chk("s_count0",   32'(count_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s_valid", 32'(inst_valid_o), 32'd1);
            chk("s_pc",    pc_o, 32'h100 + 32'(4 * i));
            chk("s_inst",  inst_o, ~(32'h100 + 32'(4 * i)));
            chk("s_pc4",   pc_plus4_o, 32'h104 + 32'(4 * i));
            chk("s_count", 32'(count_o), 32'd2);
        end

        // Asynchronous reset mid-stream, then backpressure until full
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_valid", 32'(inst_valid_o), 32'd0);
        inst_ready_i = 1'b0;
        tick();
        tick();
        base  = n_req;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_reqv",  32'(imem_req_valid_o), 32'd0);
        chk("full_pc",    pc_o, 32'h100);
        repeat (2) tick();
        chk("full_nreq",  32'(n_req - base), 32'd4);
        chk("full_reqv2", 32'(imem_req_valid_o), 32'd0);
        chk("full_valid", 32'(inst_valid_o), 32'd1);
        inst_ready_i = 1'b1;
        tick();
        chk("res_reqv",   32'(imem_req_valid_o), 32'd1);
        chk("res_addr",   imem_req_addr_o, 32'h110);
        chk("pop_pc1",    pc_o, 32'h104);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("pop_valid", 32'(inst_valid_o), 32'd1);
            chk("pop_pc",    pc_o, 32'h100 + 32'(4 * i));
        end

        // Redirect with two responses in flight, memory latency 3
        rst_n = 1'b0;
        mem_lat = 3;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rd_count2",  32'(count_o), 32'd2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        #1;
        chk("rd_reqv",    32'(imem_req_valid_o), 32'd0);
        chk("rd_valid",   32'(inst_valid_o), 32'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("rd_count0",  32'(count_o), 32'd0);
        chk("rd_reqv1",   32'(imem_req_valid_o), 32'd1);
        chk("rd_addr",    imem_req_addr_o, 32'h200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_nostale", 32'(inst_valid_o), 32'd0);
            chk("rd_cnt",     32'(count_o), 32'(i + 1));
        end
        tick();
        chk("rd_first_v", 32'(inst_valid_o), 32'd1);
        chk("rd_first_pc", pc_o, 32'h200);
        chk("rd_first_i", inst_o, ~32'h200);
        chk("rd_count4",  32'(count_o), 32'd4);

        // Redirect coinciding with a response and a pop
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        #1;
        chk("rsp_in_rd",  32'(imem_rsp_valid_i), 32'd1);
        chk("rp_valid",   32'(inst_valid_o), 32'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("rp_count",   32'(count_o), 32'd0);
        chk("rp_valid2",  32'(inst_valid_o), 32'd0);
        chk("rp_addr",    imem_req_addr_o, 32'h300);
        chk("rp_reqv",    32'(imem_req_valid_o), 32'd1);

        // Second redirect before the 0x300 stream returns
        tick();
        chk("bb_count1",  32'(count_o), 32'd1);
        chk("bb_addr1",   imem_req_addr_o, 32'h304);
        tick();
        chk("bb_count2",  32'(count_o), 32'd2);
        chk("bb_valid",   32'(inst_valid_o), 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        #1;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("bb_count0",  32'(count_o), 32'd0);
        chk("bb_addr",    imem_req_addr_o, 32'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bb_nostale", 32'(inst_valid_o), 32'd0);
        end
        chk("bb_count3",  32'(count_o), 32'd3);
        chk("bb_credit",  32'(imem_req_valid_o), 32'd1);
        tick();
        chk("bb_first_v", 32'(inst_valid_o), 32'd1);
        chk("bb_first_pc", pc_o, 32'h400);
        chk("bb_first_i", inst_o, ~32'h400);
        tick();
        chk("bb_next_v",  32'(inst_valid_o), 32'd1);
        chk("bb_next_pc", pc_o, 32'h404);

        // PC wrap at the top of the address space
        rst_n   = 1'b0;
        mem_lat = 1;
        tick();
        tick();
        rst_n         = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        #1;
        chk("w_reqv0",    32'(imem_req_valid_o), 32'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("w_addr0",    imem_req_addr_o, 32'hFFFF_FFFC);
        tick();
        chk("w_addr1",    imem_req_addr_o, 32'h0000_0000);
        chk("w_valid0",   32'(inst_valid_o), 32'd0);
        tick();
        chk("w_valid1",   32'(inst_valid_o), 32'd1);
        chk("w_pc",       pc_o, 32'hFFFF_FFFC);
        chk("w_pc4",      pc_plus4_o, 32'h0000_0000);
        chk("w_inst",     inst_o, 32'h0000_0003);
        tick();
        chk("w_pc_next",  pc_o, 32'h0000_0000);
        chk("w_pc4_next", pc_plus4_o, 32'h0000_0004);
        chk("w_inst_next", inst_o, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
